// File: rtl/j1_irq_controller.sv
// Interrupt controller for the j1 core: synchronised sources, per-source pending
// latches with edge/level mode, enable mask, fixed lowest-index priority and a vector register.
module j1_irq_controller #(
    parameter int          NSRC       = 8,
    parameter logic [15:0] BASE       = 16'h0040,
    parameter logic [14:0] EDGE_RESET = 15'h00FF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            io_rd,
    input  logic            io_wr,
    input  logic [15:0]     io_addr,
    input  logic [15:0]     io_dout,
    output logic [15:0]     io_din,
    output logic            sel,
    input  logic [NSRC-1:0] irq_src,
    output logic            interrupt_request
);

    localparam logic [2:0] OFF_PENDING = 3'd0;
    localparam logic [2:0] OFF_ENABLE  = 3'd1;
    localparam logic [2:0] OFF_EDGE    = 3'd2;
    localparam logic [2:0] OFF_VECTOR  = 3'd3;
    localparam logic [2:0] OFF_SWSET   = 3'd4;
    localparam logic [2:0] OFF_RAW     = 3'd5;

    logic [NSRC-1:0] sync1_r;
    logic [NSRC-1:0] sync2_r;
    logic [NSRC-1:0] sync3_r;
    logic [NSRC-1:0] pend_r;
    logic [NSRC-1:0] enable_r;
    logic [NSRC-1:0] edge_mode_r;
    logic [NSRC-1:0] sw_latch_r;
    logic            irq_r;

    logic [2:0]      offset_s;
    logic            wr_hit_s;
    logic            rd_hit_s;
    logic [NSRC-1:0] wdata_s;
    logic [NSRC-1:0] w1c_s;
    logic [NSRC-1:0] swset_s;
    logic [NSRC-1:0] ack_s;
    logic [NSRC-1:0] edge_s;
    logic [NSRC-1:0] active_s;
    logic            any_s;
    logic [3:0]      win_idx_s;
    logic [15:0]     vector_s;
    logic [15:0]     rd_mux_s;
    logic [NSRC-1:0] pend_next_s;
    logic [NSRC-1:0] sw_next_s;
    logic            unused_ok_s;

    function automatic logic [3:0] lowest_index(input logic [NSRC-1:0] vec);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = 4'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    assign sel         = (io_addr[15:4] == BASE[15:4]);
    assign offset_s    = io_addr[3:1];
    assign wr_hit_s    = io_wr & sel;
    assign rd_hit_s    = io_rd & sel;
    assign wdata_s     = io_dout[NSRC-1:0];
    assign edge_s      = sync2_r & ~sync3_r;
    assign active_s    = pend_r & enable_r;
    assign any_s       = |active_s;
    assign win_idx_s   = lowest_index(active_s);
    assign vector_s    = any_s ? {1'b1, 11'd0, win_idx_s} : 16'h000F;
    assign unused_ok_s = ^{io_dout, io_addr[0]};

    // Bus-side strobes: write-one-to-clear, software set and the vector-read acknowledge
    always_comb begin
        w1c_s   = {NSRC{1'b0}};
        swset_s = {NSRC{1'b0}};
        ack_s   = {NSRC{1'b0}};
        if (wr_hit_s && (offset_s == OFF_PENDING)) begin
            w1c_s = wdata_s;
        end else begin
            w1c_s = {NSRC{1'b0}};
        end
        if (wr_hit_s && (offset_s == OFF_SWSET)) begin
            swset_s = wdata_s;
        end else begin
            swset_s = {NSRC{1'b0}};
        end
        for (int i = 0; i < NSRC; i++) begin
            ack_s[i] = rd_hit_s && (offset_s == OFF_VECTOR) && any_s && (win_idx_s == 4'(i));
        end
    end

    // Per-source pending rules; in edge mode a set beats a clear in the same cycle
    always_comb begin
        pend_next_s = {NSRC{1'b0}};
        sw_next_s   = {NSRC{1'b0}};
        for (int i = 0; i < NSRC; i++) begin
            sw_next_s[i] = swset_s[i] | (sw_latch_r[i] & ~(w1c_s[i] | ack_s[i]));
            if (edge_mode_r[i]) begin
                pend_next_s[i] = edge_s[i] | swset_s[i] | (pend_r[i] & ~(w1c_s[i] | ack_s[i]));
            end else begin
                pend_next_s[i] = sync2_r[i] | sw_next_s[i];
            end
        end
    end

    // Register read multiplexer; every register is zero-extended to 16 bits
    always_comb begin
        rd_mux_s = 16'h0000;
        case (offset_s)
            OFF_PENDING: rd_mux_s = 16'(pend_r);
            OFF_ENABLE:  rd_mux_s = 16'(enable_r);
            OFF_EDGE:    rd_mux_s = 16'(edge_mode_r);
            OFF_VECTOR:  rd_mux_s = vector_s;
            OFF_RAW:     rd_mux_s = 16'(sync2_r);
            default:     rd_mux_s = 16'h0000;
        endcase
    end

    // Read data is only driven while this block is addressed
    always_comb begin
        io_din = 16'h0000;
        if (sel) begin
            io_din = rd_mux_s;
        end else begin
            io_din = 16'h0000;
        end
    end

    // Synchronisers and edge-detect history
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_r <= {NSRC{1'b0}};
            sync2_r <= {NSRC{1'b0}};
            sync3_r <= {NSRC{1'b0}};
        end else begin
            sync1_r <= irq_src;
            sync2_r <= sync1_r;
            sync3_r <= sync2_r;
        end
    end

    // Pending state, software latch and the registered request output
    always_ff @(posedge clk) begin
        if (reset) begin
            pend_r     <= {NSRC{1'b0}};
            sw_latch_r <= {NSRC{1'b0}};
            irq_r      <= 1'b0;
        end else begin
            pend_r     <= pend_next_s;
            sw_latch_r <= sw_next_s;
            irq_r      <= any_s;
        end
    end

    // Software-programmable mask and mode registers
    always_ff @(posedge clk) begin
        if (reset) begin
            enable_r    <= {NSRC{1'b0}};
            edge_mode_r <= EDGE_RESET[NSRC-1:0];
        end else begin
            if (wr_hit_s && (offset_s == OFF_ENABLE)) begin
                enable_r <= wdata_s;
            end else begin
                enable_r <= enable_r;
            end
            if (wr_hit_s && (offset_s == OFF_EDGE)) begin
                edge_mode_r <= wdata_s;
            end else begin
                edge_mode_r <= edge_mode_r;
            end
        end
    end

    assign interrupt_request = irq_r;

endmodule
